serial_link_vc_scheduler: RTL and testbench
===========================================

Name: serial_link_vc_scheduler

Overview:
- Transmit-side scheduler for the 4-bit serial inter-router link.
- Arbitrates 64-bit flits from four virtual-channel (VC) sources using round-robin, gated by per-VC credits.
- Serializes each granted flit into 16 contiguous 4-bit phits, LSB nibble first, tagged with its VC, for the receiving link deserializer.
- Tracks downstream buffer space with per-VC credit counters replenished by credit-return pulses.

Parameters:
- FLIT_W, 64, flit width in bits.
- PHIT_W, 4, serial phit width in bits.
- NUM_VC, 4, number of virtual channels (fixed; VC id is 2 bits).
- CREDIT_INIT, 4, per-VC credits after reset; equals downstream buffer depth.
- CREDIT_W, 3, credit counter width; must hold CREDIT_INIT.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- flit_in  input  256  flit for VC v at [v*64 +: 64].
- flit_valid  input  4  per-VC flit offered.
- flit_ready  output  4  one-hot grant; flit accepted when valid and ready are both high.
- credit_return  input  1  one-cycle pulse returning one credit.
- credit_vc  input  2  VC of the returned credit.
- phit_out  output  4  serial data nibble.
- phit_valid  output  1  phit_out valid.
- phit_vc  output  2  VC of the flit in flight.
- busy  output  1  high while a flit is being serialized.
- credit_count  output  12  per-VC credits, VC v at [v*3 +: 3].
- credit_err  output  1  one-cycle pulse on credit overflow.

Behaviour:
- Reset (async, immediate): state IDLE, phit_out=0, phit_valid=0, phit_vc=0, busy=0, credit_err=0, all credits=CREDIT_INIT, RR pointer=3 (VC0 has first priority), phit index=0.
- States: IDLE and SEND.
  - IDLE -> SEND on a grant.
  - SEND at index 15: grant -> SEND with index 0; no grant -> IDLE.
- Accept window: IDLE, or SEND with phit index 15.
- Eligibility: VC v is eligible if flit_valid[v]=1, registered credit[v]!=0, and the accept window is open.
- flit_ready is combinational and one-hot (or zero).
  - Winner is the first eligible VC searching pointer+1, pointer+2, … modulo 4.
  - flit_ready may depend combinationally on flit_valid; sources must not make flit_valid depend on flit_ready.
- On a grant at cycle N:
  - Latch the flit and VC; pointer <= winner; credit[winner] decrements.
  - First phit appears in cycle N+1.
- SEND: phit_out = flit[k*4 +: 4] for k=0..15 on consecutive cycles.
  - phit_valid=1 and phit_vc held constant for all 16 cycles; no gaps, since the receiver counts phits positionally.
- Back-to-back: a flit granted during index 15 puts its phit 0 in the very next cycle, so there are zero bubble cycles.
- Idle cycles: phit_valid=0, phit_out=0, phit_vc holds its last value.
- Credits:
  - credit_return increments credit[credit_vc].
  - Grant and return on the same VC in the same cycle leave the count unchanged.
  - A returned credit affects eligibility from the next cycle.
- Overflow: a return to a VC already at CREDIT_INIT (with no simultaneous consume) saturates at CREDIT_INIT and pulses credit_err for one cycle (registered, next cycle).
- Reset mid-flit: serialization aborts immediately, the partial flit is lost, and credits return to init. The downstream link shares the same reset.
- busy = (state==SEND).

Decomposition:
- Package noc_link_pkg holds:
  - constants FLIT_W=64, PHIT_W=4, PHITS_PER_FLIT=16, NUM_VC=4, VC_W=2;
  - the state encoding (IDLE, SEND).
- One sub-module, rr_arbiter_4: 4 requests plus a pointer in, one-hot grant out, purely combinational. The pointer register lives in the scheduler.
- Credit counters and the serializer stay in the top module.

Test Plan:
- Single flit: after reset, VC1 offers 64'hFEDC_BA98_7654_3210 at cycle N.
  - flit_ready=4'b0010 in cycle N.
  - phit_valid high for cycles N+1..N+16 with phit_out 0,1,2,…,F; phit_vc=1.
  - credit[1]: 4→3; busy low at N+17.
- Round-robin: all four VCs valid continuously with ample credit returns.
  - Grant order 0,1,2,3,0,….
  - phit_valid continuously high; grants exactly 16 cycles apart.
- Credit exhaustion: only VC2 valid, no returns.
  - Exactly 4 flits sent, then flit_ready[2] stays 0 and phit_valid 0.
  - credit_return with credit_vc=2 at cycle M gives a grant in cycle M+1.
- Simultaneous: VC3 at credit 1 is granted in the same cycle a VC3 credit returns.
  - credit[3] stays 1; the next VC3 flit is accepted in the next accept window.
- Overflow: credit_return on VC0 at credit 4 while idle.
  - credit[0] stays 4; credit_err high for exactly one cycle.
- Reset mid-flit: rst asserted during phit index 7.
  - phit_valid drops without waiting for a clock edge; credits read 4.
  - After release, the next granted flit starts at phit 0.

Source files
------------

// File: rtl/serial_link_vc_scheduler_pkg.sv
// Shared constants, state encoding and helpers for the serial link VC scheduler.
// Ports: none (package only).
package noc_link_pkg;

  localparam int FLIT_W         = 64;
  localparam int PHIT_W         = 4;
  localparam int PHITS_PER_FLIT = 16;
  localparam int NUM_VC         = 4;
  localparam int VC_W           = 2;
  localparam int IDX_W          = 4;
  localparam int CREDIT_INIT    = 4;
  localparam int CREDIT_W       = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Converts a one-hot VC grant into its VC number (zero when no bit is set).
  function automatic logic [VC_W-1:0] onehot_to_vc(input logic [NUM_VC-1:0] oh);
    logic [VC_W-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (oh[i]) v = VC_W'(i);
    end
    return v;
  endfunction

endpackage

// File: rtl/serial_link_vc_scheduler_if.sv
// Bundles the flit-side handshake, credit-return and serial phit signals of the scheduler.
// master: the sources / credit returner / link observer; slave: the scheduler itself.
interface serial_link_vc_scheduler_if;
  import noc_link_pkg::*;

  logic [NUM_VC*FLIT_W-1:0]   flit_in;
  logic [NUM_VC-1:0]          flit_valid;
  logic [NUM_VC-1:0]          flit_ready;
  logic                       credit_return;
  logic [VC_W-1:0]            credit_vc;
  logic [PHIT_W-1:0]          phit_out;
  logic                       phit_valid;
  logic [VC_W-1:0]            phit_vc;
  logic                       busy;
  logic [NUM_VC*CREDIT_W-1:0] credit_count;
  logic                       credit_err;

  modport master (
    output flit_in, flit_valid, credit_return, credit_vc,
    input  flit_ready, phit_out, phit_valid, phit_vc, busy, credit_count, credit_err
  );

  modport slave (
    input  flit_in, flit_valid, credit_return, credit_vc,
    output flit_ready, phit_out, phit_valid, phit_vc, busy, credit_count, credit_err
  );

endinterface

// File: rtl/serial_link_vc_scheduler_arb.sv
// Combinational four-way round-robin arbiter.
// Ports: req (4 requests), ptr (last winner), grant (one-hot or zero).
module rr_arbiter_4
  import noc_link_pkg::*;
(
  input  logic [NUM_VC-1:0] req,
  input  logic [VC_W-1:0]   ptr,
  output logic [NUM_VC-1:0] grant
);

  // Search ptr+1, ptr+2, ptr+3, ptr in that order; the 2-bit add wraps modulo 4,
  // so the most recent winner has the lowest priority.
  always_comb begin
    logic [VC_W-1:0] cand;
    logic            found;
    grant = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_VC; i++) begin
      cand = ptr + VC_W'(i);
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_link_vc_scheduler.sv
// Transmit-side scheduler: round-robin, credit-gated selection of 64-bit flits from
// four VCs, serialized into 16 gap-free 4-bit phits (LSB nibble first).
// Ports: clk, rst (async active-high), link (slave side of serial_link_vc_scheduler_if).
module serial_link_vc_scheduler
  import noc_link_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  serial_link_vc_scheduler_if.slave   link
);

  state_t              state;
  state_t              state_next;
  logic [FLIT_W-1:0]   flit_reg;
  logic [VC_W-1:0]     vc_reg;
  logic [VC_W-1:0]     ptr;
  logic [IDX_W-1:0]    idx;
  logic [CREDIT_W-1:0] credit      [NUM_VC];
  logic [CREDIT_W-1:0] credit_next [NUM_VC];
  logic [NUM_VC-1:0]   overflow;
  logic                credit_err_reg;

  logic                accept_window;
  logic [NUM_VC-1:0]   eligible;
  logic [NUM_VC-1:0]   grant;
  logic                granted;
  logic [VC_W-1:0]     winner;
  logic [FLIT_W-1:0]   flit_sel;

  // A new flit may be taken while idle or during the last phit, which is what
  // makes back-to-back flits bubble-free.
  assign accept_window = (state == IDLE) || (idx == IDX_W'(PHITS_PER_FLIT - 1));

  always_comb begin
    eligible = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      eligible[v] = link.flit_valid[v] && (credit[v] != '0) && accept_window;
    end
  end

  rr_arbiter_4 u_arb (
    .req   (eligible),
    .ptr   (ptr),
    .grant (grant)
  );

  assign granted = |grant;
  assign winner  = onehot_to_vc(grant);

  // Pick the granted VC's flit out of the wide input bus.
  always_comb begin
    flit_sel = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (grant[v]) flit_sel = link.flit_in[v*FLIT_W +: FLIT_W];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: leave SEND only when the last phit goes out with no new grant.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (granted) state_next = SEND;
      SEND:    if (idx == IDX_W'(PHITS_PER_FLIT - 1) && !granted) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Flit holding register, phit index and round-robin pointer. The pointer starts
  // at 3 so VC0 is searched first after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flit_reg <= '0;
      vc_reg   <= '0;
      ptr      <= VC_W'(NUM_VC - 1);
      idx      <= '0;
    end else begin
      if (granted) begin
        flit_reg <= flit_sel;
        vc_reg   <= winner;
        ptr      <= winner;
        idx      <= '0;
      end else if (state == SEND) begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Credit update: a consume and a return on the same VC cancel out; a lone return
  // to a full counter saturates and flags an overflow.
  always_comb begin
    logic ret;
    ret      = 1'b0;
    overflow = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      ret            = link.credit_return && (link.credit_vc == VC_W'(v));
      credit_next[v] = credit[v];
      if (grant[v] && !ret) begin
        credit_next[v] = credit[v] - 1'b1;
      end else if (ret && !grant[v]) begin
        if (credit[v] == CREDIT_W'(CREDIT_INIT)) overflow[v] = 1'b1;
        else                                     credit_next[v] = credit[v] + 1'b1;
      end
    end
  end

  // Credit counters and the registered overflow pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < NUM_VC; v++) credit[v] <= CREDIT_W'(CREDIT_INIT);
      credit_err_reg <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) credit[v] <= credit_next[v];
      credit_err_reg <= |overflow;
    end
  end

  // Outputs are decoded from registers only, so an asynchronous reset clears
  // phit_valid immediately.
  always_comb begin
    link.credit_count = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      link.credit_count[v*CREDIT_W +: CREDIT_W] = credit[v];
    end
  end

  assign link.flit_ready = grant;
  assign link.phit_valid = (state == SEND);
  assign link.phit_out   = (state == SEND) ? flit_reg[idx*PHIT_W +: PHIT_W] : '0;
  assign link.phit_vc    = vc_reg;
  assign link.busy       = (state == SEND);
  assign link.credit_err = credit_err_reg;

endmodule

// File: tb/tb_serial_link_vc_scheduler.sv
// Scoreboard bench for serial_link_vc_scheduler: stimulus pushes expected phits into a
// queue, an independent monitor pops and compares each valid phit.
module tb_serial_link_vc_scheduler;
  import noc_link_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic [5:0]  exp_q[$];
  logic [63:0] vc_data [4];

  serial_link_vc_scheduler_if link();

  serial_link_vc_scheduler dut (
    .clk  (clk),
    .rst  (rst),
    .link (link)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Generic comparison with pass/fail bookkeeping.
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic ret, input logic [1:0] rvc);
    link.flit_valid    = valid;
    link.credit_return = ret;
    link.credit_vc     = rvc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushPhits(input logic [1:0] vc, input logic [63:0] data, input int count);
    for (int k = 0; k < count; k++) exp_q.push_back({vc, data[k*4 +: 4]});
  endtask

  function automatic logic [2:0] creditOf(input int v);
    return link.credit_count[v*CREDIT_W +: CREDIT_W];
  endfunction

  // Waits (bounded) until some VC is granted; returns at the negedge of the grant cycle.
  task automatic waitGrant(output logic [3:0] g, output int gcyc);
    int n;
    n = 0;
    @(negedge clk);
    while (link.flit_ready == 4'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    g    = link.flit_ready;
    gcyc = cyc;
    if (n >= 40) checkOutput("grant timeout", 64'd1, 64'd0);
  endtask

  task automatic doReset();
    @(negedge clk);
    #1 rst = 1'b1;
    applyStimulus(4'b0, 1'b0, 2'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    tick();
  endtask

  // Monitor: every valid phit must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && link.phit_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected phit: actual vc=%0d data=%0h required none", link.phit_vc, link.phit_out);
      end else begin
        checkOutput("phit {vc,data}", 64'({link.phit_vc, link.phit_out}), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] g;
    int gc, prev;
    vc_data[0] = 64'hFEDC_BA98_7654_3210;
    vc_data[1] = 64'hFEDC_BA98_7654_3210;
    vc_data[2] = 64'h0F1E_2D3C_4B5A_6978;
    vc_data[3] = 64'h1357_9BDF_2468_ACE0;
    link.flit_in = {vc_data[3], vc_data[2], vc_data[1], vc_data[0]};
    applyStimulus(4'b0, 1'b0, 2'd0);

    // Reset state
    #12;
    checkOutput("reset phit_valid", 64'(link.phit_valid), 64'd0);
    checkOutput("reset busy", 64'(link.busy), 64'd0);
    checkOutput("reset credits", 64'(link.credit_count), 64'h924);
    checkOutput("reset phit_out", 64'(link.phit_out), 64'd0);
    checkOutput("reset phit_vc", 64'(link.phit_vc), 64'd0);
    checkOutput("reset credit_err", 64'(link.credit_err), 64'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    tick();

    // Single flit on VC1
    $display("[TB] single flit on VC1");
    applyStimulus(4'b0010, 1'b0, 2'd0);
    pushPhits(2'd1, vc_data[1], 16);
    @(negedge clk);
    checkOutput("single ready", 64'(link.flit_ready), 64'b0010);
    tick();
    applyStimulus(4'b0000, 1'b0, 2'd0);
    @(negedge clk);
    checkOutput("single credit1", 64'(creditOf(1)), 64'd3);
    checkOutput("single busy", 64'(link.busy), 64'd1);
    tick();
    repeat (15) tick();
    @(negedge clk);
    checkOutput("single busy after", 64'(link.busy), 64'd0);
    checkOutput("single idle phit_out", 64'(link.phit_out), 64'd0);
    checkOutput("single idle phit_vc held", 64'(link.phit_vc), 64'd1);

    // Round-robin with all four VCs valid
    $display("[TB] round robin");
    doReset();
    applyStimulus(4'b1111, 1'b0, 2'd0);
    for (int f = 0; f < 8; f++) pushPhits(2'(f % 4), vc_data[f % 4], 16);
    prev = 0;
    for (int f = 0; f < 8; f++) begin
      waitGrant(g, gc);
      checkOutput("rr grant", 64'(g), 64'(4'b0001 << (f % 4)));
      if (f > 0) begin
        checkOutput("rr spacing", 64'(gc - prev), 64'd16);
        checkOutput("rr continuous", 64'(link.phit_valid), 64'd1);
      end
      prev = gc;
      tick();
    end
    applyStimulus(4'b0000, 1'b0, 2'd0);
    repeat (17) tick();
    @(negedge clk);
    checkOutput("rr credits", 64'(link.credit_count), 64'h492);
    checkOutput("rr drained", 64'(link.phit_valid), 64'd0);

    // Credit exhaustion on VC2
    $display("[TB] credit exhaustion");
    doReset();
    applyStimulus(4'b0100, 1'b0, 2'd0);
    for (int f = 0; f < 4; f++) begin
      pushPhits(2'd2, vc_data[2], 16);
      waitGrant(g, gc);
      checkOutput("exh grant", 64'(g), 64'b0100);
      tick();
    end
    repeat (16) tick();
    @(negedge clk);
    checkOutput("exh ready", 64'(link.flit_ready), 64'd0);
    checkOutput("exh phit_valid", 64'(link.phit_valid), 64'd0);
    checkOutput("exh credit2", 64'(creditOf(2)), 64'd0);
    applyStimulus(4'b0100, 1'b1, 2'd2);
    tick();
    applyStimulus(4'b0100, 1'b0, 2'd0);
    pushPhits(2'd2, vc_data[2], 16);
    @(negedge clk);
    checkOutput("exh regrant", 64'(link.flit_ready), 64'b0100);
    tick();
    applyStimulus(4'b0000, 1'b0, 2'd0);
    repeat (17) tick();

    // Grant and return on VC3 in the same cycle
    $display("[TB] simultaneous consume and return");
    doReset();
    applyStimulus(4'b1000, 1'b0, 2'd0);
    for (int f = 0; f < 3; f++) begin
      pushPhits(2'd3, vc_data[3], 16);
      waitGrant(g, gc);
      tick();
    end
    pushPhits(2'd3, vc_data[3], 16);
    waitGrant(g, gc);
    checkOutput("sim grant", 64'(g), 64'b1000);
    checkOutput("sim credit before", 64'(creditOf(3)), 64'd1);
    applyStimulus(4'b1000, 1'b1, 2'd3);
    prev = gc;
    tick();
    applyStimulus(4'b1000, 1'b0, 2'd0);
    @(negedge clk);
    checkOutput("sim credit after", 64'(creditOf(3)), 64'd1);
    pushPhits(2'd3, vc_data[3], 16);
    waitGrant(g, gc);
    checkOutput("sim next grant", 64'(g), 64'b1000);
    checkOutput("sim next spacing", 64'(gc - prev), 64'd16);
    tick();
    applyStimulus(4'b0000, 1'b0, 2'd0);
    repeat (17) tick();

    // Overflow on VC0 while idle
    $display("[TB] credit overflow");
    doReset();
    applyStimulus(4'b0000, 1'b1, 2'd0);
    @(negedge clk);
    checkOutput("ovf err before", 64'(link.credit_err), 64'd0);
    tick();
    applyStimulus(4'b0000, 1'b0, 2'd0);
    @(negedge clk);
    checkOutput("ovf err pulse", 64'(link.credit_err), 64'd1);
    checkOutput("ovf credit0", 64'(creditOf(0)), 64'd4);
    tick();
    @(negedge clk);
    checkOutput("ovf err after", 64'(link.credit_err), 64'd0);

    // Reset in the middle of a flit
    $display("[TB] reset mid-flit");
    doReset();
    applyStimulus(4'b0001, 1'b0, 2'd0);
    pushPhits(2'd0, vc_data[0], 8);
    waitGrant(g, gc);
    checkOutput("mid grant", 64'(g), 64'b0001);
    tick();
    applyStimulus(4'b0000, 1'b0, 2'd0);
    repeat (7) tick();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("mid phit_valid", 64'(link.phit_valid), 64'd0);
    checkOutput("mid busy", 64'(link.busy), 64'd0);
    checkOutput("mid credits", 64'(link.credit_count), 64'h924);
    #1 rst = 1'b0;
    tick();
    applyStimulus(4'b0001, 1'b0, 2'd0);
    pushPhits(2'd0, vc_data[0], 16);
    waitGrant(g, gc);
    checkOutput("mid regrant", 64'(g), 64'b0001);
    tick();
    applyStimulus(4'b0000, 1'b0, 2'd0);
    repeat (17) tick();

    checkOutput("queue drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
